// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the two-requester data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int DEFAULT_ADDR_BITS = 10;

    // Word-aligned and inside the memory window.
    function automatic logic addr_legal(input logic [31:0] addr, input int abits);
        return (addr[1:0] == 2'b00) && ((addr >> abits) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: prio names the favoured requester on contention.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = prio;
            default: winner = 1'b0;
        endcase
        grant = (req == 2'b00) ? 2'b00 : (winner ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one registered-read data memory between two requesters,
// one access every two cycles, with address legality checking.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    state_t      state, state_next;
    logic        prio;
    logic        win_q, rd_q, err_q;
    logic [1:0]  grant;
    logic        winner;
    logic        any_req;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_legal;

    assign any_req = m0_req | m1_req;

    rr_arb2 u_pick (
        .req    ({m1_req, m0_req}),
        .prio   (prio),
        .grant  (grant),
        .winner (winner)
    );

    assign sel_we    = grant[1] ? m1_we    : m0_we;
    assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;
    assign sel_legal = addr_legal(sel_addr, ADDR_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = any_req ? RESP : IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture everything RESP needs so requester inputs are ignored there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio  <= 1'b0;
            win_q <= 1'b0;
            rd_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (state == IDLE && any_req) begin
            prio  <= ~winner;
            win_q <= winner;
            rd_q  <= sel_legal & ~sel_we;
            err_q <= ~sel_legal;
        end
    end

    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = 32'd0;
        mem_din  = 32'd0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = 32'd0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = 32'd0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (any_req && sel_legal) begin
                        mem_wr   = sel_we;
                        mem_addr = sel_addr;
                        mem_din  = sel_we ? sel_wdata : 32'd0;
                    end
                end
                RESP: begin
                    if (win_q) begin
                        m1_ack   = 1'b1;
                        m1_err   = err_q;
                        m1_rdata = rd_q ? mem_dout : 32'd0;
                    end else begin
                        m0_ack   = 1'b1;
                        m0_err   = err_q;
                        m0_rdata = rd_q ? mem_dout : 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: vector table plus response scoreboard.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_wr;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic prio_model;

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    resp_t resp_q[$];
    vec_t  vecs[13];
    logic [31:0] mem [256];

    dm_arbiter #(.ADDR_BITS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read memory sitting behind the arbiter.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[9:2]] <= mem_din;
        else        mem_dout <= mem[mem_addr[9:2]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idleInputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic applyStimulus(input logic who, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (who) begin
            m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic pushResp(input logic who, input logic err, input logic [31:0] rdata);
        resp_t r;
        r.who = who; r.err = err; r.rdata = rdata; r.cyc = cyc + 1;
        resp_q.push_back(r);
        prio_model = ~who;
    endtask

    // Every ack must match the oldest expected response, in the expected cycle.
    always @(negedge clk) begin
        resp_t r;
        if (!m0_ack) checkOutput("m0_quiet", m0_rdata | {31'd0, m0_err}, 32'd0);
        if (!m1_ack) checkOutput("m1_quiet", m1_rdata | {31'd0, m1_err}, 32'd0);
        if (m0_ack || m1_ack) begin
            if (m0_ack && m1_ack) checkOutput("double_ack", 32'd1, 32'd0);
            if (resp_q.size() == 0) begin
                checkOutput("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                r = resp_q.pop_front();
                checkOutput("ack_id", {31'd0, m1_ack}, {31'd0, r.who});
                checkOutput("ack_cycle", cyc, r.cyc);
                checkOutput("ack_err", {31'd0, r.who ? m1_err : m0_err}, {31'd0, r.err});
                checkOutput("ack_rdata", r.who ? m1_rdata : m0_rdata, r.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem_dout = 32'd0;

        //         who we  addr           wdata          wr  mem_addr      err rdata
        vecs[0]  = '{0, 1, 32'h0000_0010, 32'h1234_5678, 1, 32'h0000_0010, 0, 32'h0};
        vecs[1]  = '{1, 0, 32'h0000_0010, 32'h0,         0, 32'h0000_0010, 0, 32'h1234_5678};
        vecs[2]  = '{1, 1, 32'h0000_0402, 32'hDEAD_BEEF, 0, 32'h0,         1, 32'h0};
        vecs[3]  = '{0, 0, 32'h0000_0400, 32'h0,         0, 32'h0,         1, 32'h0};
        vecs[4]  = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'h0,         0, 32'h0};
        vecs[5]  = '{0, 1, 32'h0000_03FC, 32'hAABB_CCDD, 1, 32'h0000_03FC, 0, 32'h0};
        vecs[6]  = '{0, 0, 32'h0000_03FC, 32'h0,         0, 32'h0000_03FC, 0, 32'hAABB_CCDD};
        vecs[7]  = '{1, 1, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'h0,         0, 32'h0};
        vecs[8]  = '{1, 0, 32'h0000_0000, 32'h0,         0, 32'h0,         0, 32'hCAFE_F00D};
        vecs[9]  = '{1, 0, 32'h8000_0000, 32'h0,         0, 32'h0,         1, 32'h0};
        vecs[10] = '{0, 0, 32'h0000_0001, 32'h0,         0, 32'h0,         1, 32'h0};
        vecs[11] = '{0, 1, 32'h0000_03FD, 32'h1111_1111, 0, 32'h0,         1, 32'h0};
        vecs[12] = '{1, 0, 32'h0000_03FC, 32'h0,         0, 32'h0000_03FC, 0, 32'hAABB_CCDD};

        // Reset, with a legal write presented to prove mem_wr is held low.
        rst = 1;
        idleInputs();
        prio_model = 0;
        applyStimulus(0, 1, 32'h0000_0020, 32'h5555_5555);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idleInputs();
        @(negedge clk);
        checkOutput("idle_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("idle_mem_addr", mem_addr, 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            pushResp(vecs[i].who, vecs[i].exp_err, vecs[i].exp_rdata);
            @(negedge clk);
            checkOutput("grant_mem_wr", {31'd0, mem_wr}, {31'd0, vecs[i].exp_wr});
            checkOutput("grant_mem_addr", mem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_wr) checkOutput("grant_mem_din", mem_din, vecs[i].wdata);
            checkOutput("grant_no_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            @(posedge clk); #1;
            idleInputs();
            @(negedge clk);
            checkOutput("resp_mem_wr", {31'd0, mem_wr}, 32'd0);
            checkOutput("resp_mem_addr", mem_addr, 32'd0);
            #1;
            checkOutput("resp_pending", resp_q.size(), 32'd0);
        end

        // Contention from reset: both held, grants must alternate m0,m1,m0,m1.
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        prio_model = 0;
        @(posedge clk); #1;
        applyStimulus(0, 0, 32'h0000_0010, 32'h0);
        applyStimulus(1, 0, 32'h0000_03FC, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            checkOutput("contend_winner", {31'd0, prio_model}, {31'd0, k[0]});
            pushResp(prio_model, 0, prio_model ? 32'hAABB_CCDD : 32'h1234_5678);
            @(negedge clk);
            checkOutput("contend_mem_addr", mem_addr, resp_q[0].who ? 32'h0000_03FC : 32'h0000_0010);
            @(posedge clk);
            @(negedge clk);
            #1;
            checkOutput("contend_pending", resp_q.size(), 32'd0);
        end
        @(posedge clk); #1;
        idleInputs();

        // Reset landing in the RESP cycle of an m0 read discards the ack.
        @(posedge clk); #1;
        applyStimulus(0, 0, 32'h0000_0010, 32'h0);
        @(posedge clk); #2;
        rst = 1;
        idleInputs();
        applyStimulus(0, 1, 32'h0000_0030, 32'h7777_7777);
        @(negedge clk);
        checkOutput("rst_resp_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        idleInputs();
        prio_model = 0;
        @(posedge clk); #1;
        applyStimulus(0, 0, 32'h0000_03FC, 32'h0);
        applyStimulus(1, 0, 32'h0000_0010, 32'h0);
        pushResp(prio_model, 0, 32'hAABB_CCDD);
        @(negedge clk);
        checkOutput("post_rst_mem_addr", mem_addr, 32'h0000_03FC);
        checkOutput("post_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        idleInputs();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checkOutput("final_pending", resp_q.size(), 32'd0);
        checkOutput("mem_untouched_0x30", mem[12], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: ADDR_BITS, 10, byte-address width of the shared data memory (1024 bytes).
REQ-002 Reset is rst, asynchronous, active-high; clock is clk.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 m0_req  in  1  requester 0 access request; held until m0_ack.
REQ-006 m0_we  in  1  requester 0 write (1) / read (0).
REQ-007 m0_addr  in  32  requester 0 byte address.
REQ-008 m0_wdata  in  32  requester 0 store word, big-endian.
REQ-009 m0_ack  out  1  requester 0 one-cycle completion pulse.
REQ-010 m0_rdata  out  32  requester 0 load word, valid only while m0_ack=1.
REQ-011 m0_err  out  1  requester 0 access rejected; valid only while m0_ack=1.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same directions, widths and meaning as REQ-005..011, for requester 1.
REQ-013 mem_wr  out  1  memory write enable (to memory MemWr).
REQ-014 mem_addr  out  32  memory byte address.
REQ-015 mem_din  out  32  memory write data.
REQ-016 mem_dout  in  32  memory registered read data, valid one cycle after address presented with mem_wr=0.

Function
REQ-017 FSM states: IDLE, RESP; reset state IDLE.
REQ-018 IDLE, no req: mem_wr=0, mem_addr=0, mem_din=0; stay IDLE.
REQ-019 IDLE, any req in cycle T: select winner, drive mem_* combinationally from winner during T, go RESP at end of T.
REQ-020 Single requester: that requester wins.
REQ-021 Both requesting: winner is the requester indicated by priority bit prio; after every grant, prio = opposite of winner.
REQ-022 Legal access: addr[1:0]==0 and addr[31:ADDR_BITS]==0; otherwise illegal.
REQ-023 Legal write: mem_wr=1 during T; memory stores word at edge ending T.
REQ-024 Legal read: mem_wr=0, mem_addr=addr during T.
REQ-025 Illegal access: mem_wr=0, mem_addr=0 during T; no memory update.
REQ-026 RESP (cycle T+1): winner ack=1; err=1 iff illegal; rdata=mem_dout for legal read, 0 otherwise; loser ack=0.
REQ-027 RESP: no new grant, mem_wr=0, mem_addr=0; unconditional return to IDLE.
REQ-028 Outside winner's ack cycle: all ack, err, rdata outputs are 0.
REQ-029 Throughput: one access per 2 cycles; latency req→ack = 1 cycle.
REQ-030 Requester keeping req high in its ack cycle is a new request, sampled in the following IDLE cycle.
REQ-031 Winner id and access type are registered at end of T; requester inputs are not used in RESP.

Reset
REQ-032 On rst: state=IDLE, prio=0 (m0 favoured), winner and error registers cleared.
REQ-033 During rst: mem_wr=0 combinationally; all ack/err/rdata outputs 0.
REQ-034 rst mid-RESP: pending ack discarded; requester re-requests after release.

Structure
REQ-035 Package dm_arb_pkg holds the FSM state enum and default ADDR_BITS.
REQ-036 Sub-module rr_arb2: 2-way round-robin picker (inputs req[1:0], prio; outputs grant[1:0], winner id).

Verification
REQ-037 m0 write 0x12345678 @0x10; then m1 read @0x10 → m1_ack in cycle after grant, m1_rdata=0x12345678, err=0.
REQ-038 m0,m1 request together, from reset → m0 granted first, m1 acked two cycles later; both held continuously → grants alternate m0,m1,m0,m1.
REQ-039 m1 write @0x0000_0402 (misaligned) → mem_wr stays 0, m1_ack=1 with m1_err=1; memory unchanged.
REQ-040 m0 read @0x0000_0400 (out of range) → m0_err=1, m0_rdata=0, mem_addr=0.
REQ-041 Assert rst in RESP of a read → no ack pulse; after release, state IDLE, prio=0, mem_wr=0.
REQ-042 m0 writes 0xAABBCCDD @0x3FC → read back returns 0xAABBCCDD; m0_ack never asserted on non-grant cycles.
